// File: rtl/mousetrap_pkg.sv
// Shared definitions for the clocked MOUSETRAP-style two-phase FIFO.
package mousetrap_pkg;

  localparam int   DEFAULT_DATA_WIDTH = 4;
  localparam int   DEFAULT_DEPTH      = 4;
  // Every two-phase wire rests at this level after reset.
  localparam logic PHASE_IDLE         = 1'b0;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mousetrap_pipe_sync_phase_sync.sv
// Phase synchroniser: STAGES-deep flop chain on a 1-bit two-phase signal.
// With STAGES = 0 the input is already in the clk domain and passes straight through.
module phase_sync
  import mousetrap_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_wire
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] chain;

    // Shift the incoming phase through the chain; the last flop is the synchronised view.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain <= {STAGES{PHASE_IDLE}};
      end else begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/mousetrap_pipe_sync.sv
// Bundled-data FIFO with two-phase req/ack on both sides. The head entry is
// popped into data_out when issued, so the stage holds DEPTH buffered tokens
// plus one in flight downstream.
module mousetrap_pipe_sync
  import mousetrap_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int SYNC_STAGES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        req_in,
  output logic                        ack_out,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        req_out,
  input  logic                        ack_in,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        full,
  output logic                        empty
);

  localparam int CNT_W = clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  req_s;
  logic                  ack_s;
  logic                  in_pend;
  logic                  out_idle;
  logic                  accept;
  logic                  issue;

  // Pointer increment with wrap at DEPTH-1, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  phase_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_in),
    .q     (req_s)
  );

  phase_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_in),
    .q     (ack_s)
  );

  // A request is pending while the upstream phase differs from our ack phase;
  // the output is free once downstream has matched our request phase.
  assign in_pend  = req_s ^ ack_out;
  assign out_idle = (req_out == ack_s);
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // Both use pre-edge occupancy: a same-edge issue does not make room for an accept.
  assign accept   = in_pend && !full;
  assign issue    = out_idle && !empty;

  // Storage array: written on accept, deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_in;
  end

  // Upstream side: write pointer advance and ack phase toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      ack_out <= PHASE_IDLE;
    end else if (accept) begin
      wr_ptr  <= next_ptr(wr_ptr);
      ack_out <= ~ack_out;
    end
  end

  // Downstream side: pop head into data_out, advance read pointer, toggle req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      req_out  <= PHASE_IDLE;
      data_out <= '0;
    end else if (issue) begin
      rd_ptr   <= next_ptr(rd_ptr);
      req_out  <= ~req_out;
      data_out <= mem[rd_ptr];
    end
  end

  // Occupancy of the buffer, excluding the token already presented downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({accept, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mousetrap_pipe_sync.sv
// Directed bench for mousetrap_pipe_sync: default build, DEPTH=3 build and
// SYNC_STAGES=2 build share one clock and reset.
module tb_mousetrap_pipe_sync;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  // DEPTH=4, SYNC_STAGES=0
  logic [3:0] d4_data_in, d4_data_out;
  logic       d4_req_in, d4_ack_out, d4_req_out, d4_ack_in, d4_full, d4_empty;
  logic [2:0] d4_count;
  // DEPTH=3, SYNC_STAGES=0
  logic [3:0] d3_data_in, d3_data_out;
  logic       d3_req_in, d3_ack_out, d3_req_out, d3_ack_in, d3_full, d3_empty;
  logic [1:0] d3_count;
  // DEPTH=4, SYNC_STAGES=2
  logic [3:0] s2_data_in, s2_data_out;
  logic       s2_req_in, s2_ack_out, s2_req_out, s2_ack_in, s2_full, s2_empty;
  logic [2:0] s2_count;

  always #5 clk = ~clk;

  mousetrap_pipe_sync #(.DATA_WIDTH(4), .DEPTH(4), .SYNC_STAGES(0)) u_d4 (
    .clk(clk), .reset(reset), .data_in(d4_data_in), .req_in(d4_req_in),
    .ack_out(d4_ack_out), .data_out(d4_data_out), .req_out(d4_req_out),
    .ack_in(d4_ack_in), .count(d4_count), .full(d4_full), .empty(d4_empty));

  mousetrap_pipe_sync #(.DATA_WIDTH(4), .DEPTH(3), .SYNC_STAGES(0)) u_d3 (
    .clk(clk), .reset(reset), .data_in(d3_data_in), .req_in(d3_req_in),
    .ack_out(d3_ack_out), .data_out(d3_data_out), .req_out(d3_req_out),
    .ack_in(d3_ack_in), .count(d3_count), .full(d3_full), .empty(d3_empty));

  mousetrap_pipe_sync #(.DATA_WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) u_s2 (
    .clk(clk), .reset(reset), .data_in(s2_data_in), .req_in(s2_req_in),
    .ack_out(s2_ack_out), .data_out(s2_data_out), .req_out(s2_req_out),
    .ack_in(s2_ack_in), .count(s2_count), .full(s2_full), .empty(s2_empty));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  initial begin
    d4_data_in = '0; d4_req_in = 1'b0; d4_ack_in = 1'b0;
    d3_data_in = '0; d3_req_in = 1'b0; d3_ack_in = 1'b0;
    s2_data_in = '0; s2_req_in = 1'b0; s2_ack_in = 1'b0;

    // Power-on reset state
    tick(); tick();
    check("rst_count",    32'(d4_count),    0);
    check("rst_empty",    32'(d4_empty),    1);
    check("rst_full",     32'(d4_full),     0);
    check("rst_ack_out",  32'(d4_ack_out),  0);
    check("rst_req_out",  32'(d4_req_out),  0);
    check("rst_data_out", 32'(d4_data_out), 0);
    reset = 1'b0;
    tick();

    // Single token A
    d4_data_in = 4'hA; d4_req_in = 1'b1;
    tick();
    check("single_e0_ack",   32'(d4_ack_out), 1);
    check("single_e0_count", 32'(d4_count),   1);
    check("single_e0_req",   32'(d4_req_out), 0);
    tick();
    check("single_e1_req",   32'(d4_req_out),  1);
    check("single_e1_data",  32'(d4_data_out), 4'hA);
    check("single_e1_count", 32'(d4_count),    0);
    check("single_e1_empty", 32'(d4_empty),    1);
    d4_ack_in = 1'b1;
    tick(); tick();
    check("single_quiet_req", 32'(d4_req_out), 1);
    check("single_quiet_ack", 32'(d4_ack_out), 1);

    // Fill with ack_in held: tokens 1..6
    for (int k = 1; k <= 6; k++) begin
      d4_data_in = 4'(k); d4_req_in = ~d4_req_in;
      tick();
    end
    check("fill_count", 32'(d4_count),    4);
    check("fill_full",  32'(d4_full),     1);
    check("fill_empty", 32'(d4_empty),    0);
    check("fill_data",  32'(d4_data_out), 1);
    check("fill_ack",   32'(d4_ack_out),  0);
    check("fill_req",   32'(d4_req_out),  0);
    d4_ack_in = ~d4_ack_in;
    tick();
    check("unblock_data",  32'(d4_data_out), 2);
    check("unblock_count", 32'(d4_count),    3);
    check("unblock_ack",   32'(d4_ack_out),  0);
    check("unblock_req",   32'(d4_req_out),  1);
    tick();
    check("accept6_ack",   32'(d4_ack_out), 1);
    check("accept6_count", 32'(d4_count),   4);
    check("accept6_full",  32'(d4_full),    1);

    // Drain in order through pointer wrap
    for (int k = 3; k <= 6; k++) begin
      d4_ack_in = ~d4_ack_in;
      tick();
      check($sformatf("drain_data_%0d", k),  32'(d4_data_out), 32'(k));
      check($sformatf("drain_count_%0d", k), 32'(d4_count),    32'(6 - k));
    end
    d4_ack_in = ~d4_ack_in;
    tick(); tick();
    check("drain_empty", 32'(d4_empty),   1);
    check("drain_req",   32'(d4_req_out), 1);

    // DEPTH=3: two fill/drain rounds to wrap the non-power-of-two pointers
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 4; k++) begin
        d3_data_in = 4'(r * 4 + k); d3_req_in = ~d3_req_in;
        tick();
      end
      check($sformatf("d3_full_r%0d", r),  32'(d3_full),     1);
      check($sformatf("d3_count_r%0d", r), 32'(d3_count),    3);
      check($sformatf("d3_head_r%0d", r),  32'(d3_data_out), 32'(r * 4 + 1));
      for (int k = 2; k <= 4; k++) begin
        d3_ack_in = ~d3_ack_in;
        tick();
        check($sformatf("d3_data_r%0d_%0d", r, k), 32'(d3_data_out), 32'(r * 4 + k));
      end
      d3_ack_in = ~d3_ack_in;
      tick();
      check($sformatf("d3_empty_r%0d", r), 32'(d3_empty), 1);
    end

    // Simultaneous accept and issue at count=2
    d4_data_in = 4'h8; d4_req_in = ~d4_req_in; tick();
    d4_data_in = 4'h9; d4_req_in = ~d4_req_in; tick();
    d4_data_in = 4'hB; d4_req_in = ~d4_req_in; tick();
    check("simul_pre_count", 32'(d4_count),    2);
    check("simul_pre_data",  32'(d4_data_out), 4'h8);
    d4_data_in = 4'hC; d4_req_in = ~d4_req_in; d4_ack_in = ~d4_ack_in;
    tick();
    check("simul_count", 32'(d4_count),    2);
    check("simul_ack",   32'(d4_ack_out),  1);
    check("simul_req",   32'(d4_req_out),  1);
    check("simul_data",  32'(d4_data_out), 4'h9);

    // SYNC_STAGES=2 latency
    s2_data_in = 4'h3; s2_req_in = 1'b1;
    tick();
    check("s2_e0_ack", 32'(s2_ack_out), 0);
    tick();
    check("s2_e1_ack", 32'(s2_ack_out), 0);
    tick();
    check("s2_e2_ack", 32'(s2_ack_out), 1);
    check("s2_e2_req", 32'(s2_req_out), 0);
    tick();
    check("s2_e3_req",  32'(s2_req_out),  1);
    check("s2_e3_data", 32'(s2_data_out), 4'h3);
    s2_data_in = 4'h5; s2_req_in = 1'b0;
    tick(); tick();
    check("s2_tok2_wait_ack", 32'(s2_ack_out), 1);
    tick();
    check("s2_tok2_ack",   32'(s2_ack_out), 0);
    check("s2_tok2_count", 32'(s2_count),   1);
    s2_ack_in = 1'b1;
    tick();
    check("s2_f0_req", 32'(s2_req_out), 1);
    tick();
    check("s2_f1_req", 32'(s2_req_out), 1);
    tick();
    check("s2_f2_req",   32'(s2_req_out),  0);
    check("s2_f2_data",  32'(s2_data_out), 4'h5);
    check("s2_f2_count", 32'(s2_count),    0);

    // Reset mid-operation with count=3
    d4_data_in = 4'hD; d4_req_in = ~d4_req_in;
    tick();
    check("midrst_pre_count", 32'(d4_count), 3);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_count",    32'(d4_count),    0);
    check("midrst_empty",    32'(d4_empty),    1);
    check("midrst_full",     32'(d4_full),     0);
    check("midrst_req_out",  32'(d4_req_out),  0);
    check("midrst_ack_out",  32'(d4_ack_out),  0);
    check("midrst_data_out", 32'(d4_data_out), 0);
    d4_req_in = 1'b0; d4_ack_in = 1'b0;
    d3_req_in = 1'b0; d3_ack_in = 1'b0;
    s2_req_in = 1'b0; s2_ack_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    d4_data_in = 4'h7; d4_req_in = 1'b1;
    tick();
    check("postrst_ack", 32'(d4_ack_out), 1);
    tick();
    check("postrst_req",  32'(d4_req_out),  1);
    check("postrst_data", 32'(d4_data_out), 4'h7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
